// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB,
// handshakes with memory via mem_ready and traps illegal encodings or memory timeouts.
`timescale 1ns/1ps
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned ALU_CTRL_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opcode,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic                  mem_ready,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  branch,
  output logic                  mem_to_reg,
  output logic                  alu_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  instr_done,
  output logic                  illegal_instr,
  output logic                  mem_fault,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WB      = 3'd5,
    TRAP    = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;

  // Counter only ever needs to reach MEM_TIMEOUT-1; with the timeout disabled it may wrap freely.
  localparam int unsigned     CNT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           cur_state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             legal;
  logic             waiting;
  logic             timeout_hit;
  logic [3:0]       alu_op;

  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_R:      legal = (func7 == '0) || (func7 == F7_ALT && (func3 == 3'b000 || func3 == 3'b101));
      OP_I: begin
        case (func3)
          3'b001:  legal = (func7 == '0);
          3'b101:  legal = (func7 == '0) || (func7 == F7_ALT);
          default: legal = 1'b1;
        endcase
      end
      OP_LOAD:   legal = (func3 != 3'b011) && (func3 != 3'b110) && (func3 != 3'b111);
      OP_STORE:  legal = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
      OP_BRANCH: legal = (func3 != 3'b010) && (func3 != 3'b011);
      default:   legal = 1'b0;
    endcase
  end

  assign waiting     = (cur_state == FETCH) || (cur_state == MEM);
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt == CNT_LAST);

  always_comb begin
    next_state = cur_state;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    instr_done = 1'b0;
    case (cur_state)
      IDLE: next_state = FETCH;
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = DECODE;
        end else if (timeout_hit) begin
          next_state = TRAP;
        end
      end
      DECODE: next_state = legal ? EXECUTE : TRAP;
      EXECUTE: begin
        case (opcode)
          OP_R: begin
            alu_op     = arith_op(func3, func7[5]);
            next_state = WB;
          end
          OP_I: begin
            alu_src    = 1'b1;
            alu_op     = arith_op(func3, (func3 == 3'b101) && func7[5]);
            next_state = WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src    = 1'b1;
            next_state = MEM;
          end
          OP_BRANCH: begin
            branch     = 1'b1;
            instr_done = 1'b1;
            alu_op     = func3[2] ? (func3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            next_state = FETCH;
          end
          default: next_state = TRAP;
        endcase
      end
      MEM: begin
        alu_src = 1'b1;
        if (opcode == OP_STORE) mem_write = 1'b1;
        else                    mem_read  = 1'b1;
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            instr_done = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = WB;
          end
        end else if (timeout_hit) begin
          next_state = TRAP;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
        next_state = FETCH;
      end
      TRAP:    next_state = TRAP;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state     <= IDLE;
      wait_cnt      <= '0;
      illegal_instr <= 1'b0;
      mem_fault     <= 1'b0;
    end else begin
      cur_state <= next_state;
      if (!waiting || mem_ready || next_state != cur_state) wait_cnt <= '0;
      else                                                   wait_cnt <= wait_cnt + 1'b1;
      if (cur_state == DECODE && !legal) illegal_instr <= 1'b1;
      if (waiting && timeout_hit)        mem_fault     <= 1'b1;
    end
  end

  assign alu_control = ALU_CTRL_W'(alu_op);
  assign state       = cur_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each instruction is expanded into its expected per-cycle trace from the
// instruction-level rules; a negedge monitor pops and compares one entry per cycle.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  localparam int unsigned TMO = 4;
  localparam int unsigned AW  = 5;

  localparam logic [6:0] R_OP = 7'b0110011;
  localparam logic [6:0] I_OP = 7'b0010011;
  localparam logic [6:0] L_OP = 7'b0000011;
  localparam logic [6:0] S_OP = 7'b0100011;
  localparam logic [6:0] B_OP = 7'b1100011;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
                         ST_MEM = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd7;

  logic          clk, rst_n, mem_ready;
  logic [6:0]    opcode, func7;
  logic [2:0]    func3;
  logic [AW-1:0] alu_control;
  logic          reg_write, mem_read, mem_write, branch, mem_to_reg, alu_src;
  logic          ir_write, pc_write, instr_done, illegal_instr, mem_fault;
  logic [2:0]    state;

  multicycle_control_unit #(.MEM_TIMEOUT(TMO), .ALU_CTRL_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
    .mem_ready(mem_ready), .alu_control(alu_control), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .ir_write(ir_write), .pc_write(pc_write), .instr_done(instr_done),
    .illegal_instr(illegal_instr), .mem_fault(mem_fault), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic [AW-1:0] alu;
    logic rw, mr, mw, br, m2r, asrc, irw, pcw, done, ill, flt;
  } obs_t;

  obs_t exp_q[$];
  int   tag_q[$];
  int   checks = 0;
  int   errors = 0;
  int   instr_id = 0;
  logic ill_m, flt_m;
  obs_t act_now;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      int   t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      act_now = {state, alu_control, reg_write, mem_read, mem_write, branch, mem_to_reg,
                 alu_src, ir_write, pc_write, instr_done, illegal_instr, mem_fault};
      checks++;
      if (act_now !== e) begin
        errors++;
        $display("FAIL cycle_outputs instr %0d: state got %0d want %0d, vector got %h want %h",
                 t, act_now.st, e.st, act_now, e);
      end
    end
  end

  function automatic obs_t mk(input logic [2:0] st);
    obs_t r;
    r     = '0;
    r.st  = st;
    r.alu = AW'(4'b0010);
    r.ill = ill_m;
    r.flt = flt_m;
    return r;
  endfunction

  function automatic bit legal_ref(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    if (op == R_OP) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (op == I_OP) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
      return 1'b1;
    end
    if (op == L_OP) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (op == S_OP) return f3 inside {3'd0, 3'd1, 3'd2};
    if (op == B_OP) return !(f3 inside {3'd2, 3'd3});
    return 1'b0;
  endfunction

  // Arithmetic op selected by func3, with the alternate (SUB/SRA) form when alt is set.
  function automatic logic [3:0] alu_ref(input logic [2:0] f3, input bit alt);
    if (alt && f3 == 3'd0) return 4'b0110;
    if (alt && f3 == 3'd5) return 4'b1100;
    case (f3)
      3'd0: return 4'b0010;
      3'd1: return 4'b1010;
      3'd2: return 4'b0111;
      3'd3: return 4'b1000;
      3'd4: return 4'b1001;
      3'd5: return 4'b1011;
      3'd6: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] br_ref(input logic [2:0] f3);
    if (f3 inside {3'd0, 3'd1}) return 4'b0110;
    if (f3 inside {3'd4, 3'd5}) return 4'b0111;
    return 4'b1000;
  endfunction

  task automatic step(input obs_t r, input logic rdy);
    mem_ready = rdy;
    exp_q.push_back(r);
    tag_q.push_back(instr_id);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    ill_m = 1'b0;
    flt_m = 1'b0;
    step(mk(ST_IDLE), rnd_bit());
    rst_n = 1'b1;
    step(mk(ST_IDLE), rnd_bit());
  endtask

  // Wait phase shared by FETCH and MEM: `waits` low cycles then ready, unless TMO lows come first.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int fw, input int mw, output bit trapped);
    obs_t r;
    logic rdy;
    bit   st_op;
    trapped = 1'b0;
    instr_id++;
    opcode = op;
    func3  = f3;
    func7  = f7;
    for (int k = 0; k <= fw; k++) begin
      r    = mk(ST_FETCH);
      r.mr = 1'b1;
      rdy  = (k == fw);
      if (rdy) begin
        r.irw = 1'b1;
        r.pcw = 1'b1;
      end
      step(r, rdy);
      if (rdy) break;
      if (k + 1 == TMO) begin
        flt_m = 1'b1;
        trapped = 1'b1;
        return;
      end
    end
    step(mk(ST_DECODE), rnd_bit());
    if (!legal_ref(op, f3, f7)) begin
      ill_m = 1'b1;
      trapped = 1'b1;
      return;
    end
    r = mk(ST_EXEC);
    if (op == B_OP) begin
      r.br   = 1'b1;
      r.done = 1'b1;
      r.alu  = AW'(br_ref(f3));
      step(r, rnd_bit());
      return;
    end
    if (op == R_OP) begin
      r.alu = AW'(alu_ref(f3, f7[5]));
    end else if (op == I_OP) begin
      r.asrc = 1'b1;
      r.alu  = AW'(alu_ref(f3, f3 == 3'd5 && f7[5]));
    end else begin
      r.asrc = 1'b1;
    end
    step(r, rnd_bit());
    if (op == L_OP || op == S_OP) begin
      st_op = (op == S_OP);
      for (int k = 0; k <= mw; k++) begin
        r      = mk(ST_MEM);
        r.asrc = 1'b1;
        if (st_op) r.mw = 1'b1;
        else       r.mr = 1'b1;
        rdy = (k == mw);
        if (rdy && st_op) r.done = 1'b1;
        step(r, rdy);
        if (rdy) break;
        if (k + 1 == TMO) begin
          flt_m = 1'b1;
          trapped = 1'b1;
          return;
        end
      end
      if (st_op) return;
    end
    r      = mk(ST_WB);
    r.rw   = 1'b1;
    r.done = 1'b1;
    r.m2r  = (op == L_OP);
    step(r, rnd_bit());
  endtask

  task automatic exec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input int fw, input int mw);
    bit t;
    run_instr(op, f3, f7, fw, mw, t);
    if (t) begin
      for (int i = 0; i < 3; i++) step(mk(ST_TRAP), rnd_bit());
      do_reset();
    end
  endtask

  task automatic lw_abort();
    obs_t r;
    instr_id++;
    opcode = L_OP;
    func3  = 3'd2;
    func7  = 7'h00;
    r = mk(ST_FETCH); r.mr = 1'b1; r.irw = 1'b1; r.pcw = 1'b1;
    step(r, 1'b1);
    step(mk(ST_DECODE), 1'b0);
    r = mk(ST_EXEC); r.asrc = 1'b1;
    step(r, 1'b0);
    r = mk(ST_MEM); r.asrc = 1'b1; r.mr = 1'b1;
    step(r, 1'b0);
    do_reset();
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; func3 = '0; func7 = '0;
    ill_m = 1'b0; flt_m = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    exec(R_OP, 3'd0, 7'h00, 0, 0);
    exec(R_OP, 3'd0, 7'h20, 0, 0);
    exec(I_OP, 3'd5, 7'h20, 0, 0);
    exec(L_OP, 3'd2, 7'h00, 0, 3);
    exec(S_OP, 3'd2, 7'h00, 0, 0);
    exec(B_OP, 3'd4, 7'h00, 0, 0);
    exec(L_OP, 3'd2, 7'h00, TMO - 1, TMO - 1);
    exec(7'h7f, 3'd0, 7'h00, 0, 0);
    exec(R_OP, 3'd4, 7'h20, 0, 0);
    exec(I_OP, 3'd1, 7'h20, 0, 0);
    exec(R_OP, 3'd0, 7'h00, 6, 0);
    exec(S_OP, 3'd0, 7'h00, 1, 5);
    lw_abort();
    exec(I_OP, 3'd0, 7'h00, 0, 0);

    repeat (300) begin
      logic [6:0] op, f7;
      logic [2:0] f3;
      int sel, fw, mw;
      sel = int'($urandom_range(0, 9));
      f3  = 3'($urandom);
      case ($urandom_range(0, 9))
        0:       f7 = 7'($urandom);
        1, 2:    f7 = 7'h20;
        default: f7 = 7'h00;
      endcase
      case (sel)
        0, 1, 9: op = R_OP;
        2, 3:    op = I_OP;
        4:       op = L_OP;
        5:       op = S_OP;
        6, 7:    op = B_OP;
        default: op = 7'($urandom);
      endcase
      fw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 5));
      mw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(3, 5));
      exec(op, f3, f7, fw, mw);
    end

    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
